// File: rtl/avr_io_i2c.sv
// rtl/avr_io_i2c.sv - I2C master on the AVR I/O bus with a 4-register window
// Define I2C_CLOCK_STRETCH_EN to hold the quarter timer in BIT/STOP Q2 until scl_i is high.
module avr_io_i2c #(
  parameter logic [7:0] PRESCALE_RST = 8'd24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [1:0] io_a,
  output logic [7:0] io_di,
  input  logic [7:0] io_do,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       irq
);
  typedef enum logic [2:0] {IDLE, START, BIT, STOP, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d, data_q, data_d, shift_q, shift_d, presc_q, presc_d;
  logic [1:0] qtr_q, qtr_d;
  logic [3:0] bit_q, bit_d;
  logic       ien_q, ien_d, if_q, if_d, rxnack_q, rxnack_d;
  logic       busact_q, busact_d, busy_q, busy_d, irq_q, irq_d;
  logic       sto_q, sto_d, wr_q, wr_d, rd_q, rd_d, nack_q, nack_d, rs_q, rs_d;
  logic       hold, tick, phase_end, xfer_done;
  logic [7:0] rdata;

`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = (state_q == BIT || state_q == STOP) && (qtr_q == 2'd2) && !scl_i;
`else
  logic unused_scl_i;
  assign hold = 1'b0;
  assign unused_scl_i = scl_i;
`endif

  assign tick      = !hold && (cnt_q == presc_q);
  assign phase_end = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;     qtr_d = qtr_q;       bit_d = bit_q;
    data_d = data_q;    shift_d = shift_q; presc_d = presc_q;   ien_d = ien_q;
    if_d = if_q;        rxnack_d = rxnack_q; busact_d = busact_q; busy_d = busy_q;
    sto_d = sto_q;      wr_d = wr_q;       rd_d = rd_q;         nack_d = nack_q;
    rs_d = rs_q;        irq_d = if_q & ien_q;
    scl_oe = 1'b0;      sda_oe = 1'b0;     xfer_done = 1'b0;

    if (io_we && io_a == 2'd2 && io_do[2]) if_d = 1'b0;

    if (state_q == START || state_q == BIT || state_q == STOP) begin
      cnt_d = (hold || tick) ? 8'd0 : cnt_q + 8'd1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end

    case (state_q)
      IDLE: scl_oe = busact_q;
      DONE: begin
        scl_oe  = busact_q;
        state_d = IDLE;
      end
      START: begin
        // A repeated start first drops SCL so SDA can be released safely
        scl_oe = (qtr_q == 2'd0) && rs_q;
        sda_oe = qtr_q[1];
        if (phase_end) begin
          busact_d = 1'b1;
          bit_d    = 4'd0;
          if (wr_q || rd_q) state_d = BIT;
          else if (sto_q)   state_d = STOP;
          else              xfer_done = 1'b1;
        end
      end
      BIT: begin
        scl_oe = !qtr_q[1];
        if (bit_q == 4'd8) sda_oe = rd_q && !nack_q;
        else               sda_oe = wr_q && !shift_q[7];
        if (phase_end) begin
          if (bit_q == 4'd8) begin
            if (wr_q) rxnack_d = sda_i;
            bit_d = 4'd0;
            if (sto_q) state_d = STOP;
            else       xfer_done = 1'b1;
          end else begin
            if (wr_q) shift_d = {shift_q[6:0], 1'b0};
            else      data_d  = {data_q[6:0], sda_i};
            bit_d = bit_q + 4'd1;
          end
        end
      end
      STOP: begin
        scl_oe = (qtr_q == 2'd0);
        sda_oe = (qtr_q != 2'd3);
        if (phase_end) begin
          busact_d  = 1'b0;
          xfer_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer_done) begin
      state_d = DONE;
      busy_d  = 1'b0;
      if_d    = 1'b1;
    end

    if (io_we && !busy_q) begin
      case (io_a)
        2'd0: data_d = io_do;
        2'd1: begin
          ien_d = io_do[7];
          if (|io_do[3:0]) begin
            sto_d   = io_do[1];
            wr_d    = io_do[2];
            rd_d    = io_do[3] && !io_do[2];
            nack_d  = io_do[4];
            rs_d    = busact_q;
            shift_d = data_q;
            if_d    = 1'b0;
            busy_d  = 1'b1;
            cnt_d   = 8'd0;
            qtr_d   = 2'd0;
            bit_d   = 4'd0;
            if (io_do[0])                 state_d = START;
            else if (io_do[2] || io_do[3]) state_d = BIT;
            else                          state_d = STOP;
          end
        end
        2'd3: presc_d = io_do;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (io_a)
      2'd0: rdata = data_q;
      2'd1: rdata = {ien_q, 7'b0};
      2'd2: rdata = {4'b0, busact_q, if_q, rxnack_q, busy_q};
      2'd3: rdata = presc_q;
      default: rdata = 8'h00;
    endcase
  end

  assign io_di = io_re ? rdata : 8'hzz;
  assign irq   = irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;   cnt_q <= 8'd0;    qtr_q <= 2'd0;      bit_q <= 4'd0;
      data_q <= 8'd0;    shift_q <= 8'd0;  presc_q <= PRESCALE_RST;
      ien_q <= 1'b0;     if_q <= 1'b0;     rxnack_q <= 1'b0;   busact_q <= 1'b0;
      busy_q <= 1'b0;    irq_q <= 1'b0;    sto_q <= 1'b0;      wr_q <= 1'b0;
      rd_q <= 1'b0;      nack_q <= 1'b0;   rs_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;     qtr_q <= qtr_d;       bit_q <= bit_d;
      data_q <= data_d;   shift_q <= shift_d; presc_q <= presc_d;
      ien_q <= ien_d;     if_q <= if_d;       rxnack_q <= rxnack_d; busact_q <= busact_d;
      busy_q <= busy_d;   irq_q <= irq_d;     sto_q <= sto_d;       wr_q <= wr_d;
      rd_q <= rd_d;       nack_q <= nack_d;   rs_q <= rs_d;
    end
  end
endmodule
